// File: rtl/adder_tree_accumulator_pkg.sv
// Shared definitions for the adder-tree frame accumulator: FSM states and the
// accumulator width rule so downstream blocks size their inputs identically.
package adder_tree_accumulator_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    localparam int DEF_DATA_WIDTH  = 20;
    localparam int DEF_COUNT_WIDTH = 16;

    // A frame of at most 2^count_width-1 samples can never overflow this width.
    function automatic int acc_width(input int data_width, input int count_width);
        return data_width + count_width;
    endfunction

endpackage

// File: rtl/adder_tree_accumulator.sv
// Frame accumulator behind the adder tree: sums frame_len valid samples into one
// wide signed total and strobes it out once per frame (decimation by frame_len).
module adder_tree_accumulator
    import adder_tree_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, COUNT_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         sync,
    input  logic [COUNT_WIDTH-1:0]       frame_len,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         valid_out,
    output logic signed [ACC_WIDTH-1:0]  data_out,
    output logic                         frame_err
);

    acc_state_t                  state, state_nxt;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
    logic signed [ACC_WIDTH-1:0] data_out_nxt;
    logic signed [ACC_WIDTH-1:0] data_ext;
    logic [COUNT_WIDTH-1:0]      remaining, remaining_nxt;
    logic                        valid_nxt;
    logic                        err_nxt;
    logic                        len_zero;
    logic                        len_one;

    function automatic logic signed [ACC_WIDTH-1:0] sign_extend(
        input logic signed [DATA_WIDTH-1:0] d
    );
        return {{(ACC_WIDTH-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
    endfunction

    assign data_ext = sign_extend(data_in);
    assign len_zero = (frame_len == '0);
    assign len_one  = (frame_len == COUNT_WIDTH'(1));

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        remaining_nxt = remaining;
        data_out_nxt  = data_out;
        valid_nxt     = 1'b0;
        err_nxt       = frame_err;

        if (!enable) begin
            // Partial frame is dropped silently; data_out keeps the last total.
            state_nxt     = IDLE;
            acc_nxt       = '0;
            remaining_nxt = '0;
            err_nxt       = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    acc_nxt       = '0;
                    remaining_nxt = '0;
                    if (len_zero) begin
                        err_nxt = 1'b1;
                    end else begin
                        remaining_nxt = frame_len;
                        state_nxt     = ACCUM;
                    end
                end

                ACCUM: begin
                    if (sync) begin
                        // Restart wins over completing the old frame.
                        if (len_zero) begin
                            err_nxt       = 1'b1;
                            state_nxt     = IDLE;
                            acc_nxt       = '0;
                            remaining_nxt = '0;
                        end else if (valid_in && len_one) begin
                            data_out_nxt  = data_ext;
                            valid_nxt     = 1'b1;
                            acc_nxt       = '0;
                            remaining_nxt = frame_len;
                        end else if (valid_in) begin
                            acc_nxt       = data_ext;
                            remaining_nxt = frame_len - COUNT_WIDTH'(1);
                        end else begin
                            acc_nxt       = '0;
                            remaining_nxt = frame_len;
                        end
                    end else if (valid_in) begin
                        if (remaining > COUNT_WIDTH'(1)) begin
                            acc_nxt       = acc + data_ext;
                            remaining_nxt = remaining - COUNT_WIDTH'(1);
                        end else begin
                            data_out_nxt = acc + data_ext;
                            valid_nxt    = 1'b1;
                            acc_nxt      = '0;
                            if (len_zero) begin
                                err_nxt       = 1'b1;
                                state_nxt     = IDLE;
                                remaining_nxt = '0;
                            end else begin
                                remaining_nxt = frame_len;
                            end
                        end
                    end
                end

                default: begin
                    state_nxt     = IDLE;
                    acc_nxt       = '0;
                    remaining_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            remaining <= remaining_nxt;
            valid_out <= valid_nxt;
            data_out  <= data_out_nxt;
            frame_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Scoreboard bench for adder_tree_accumulator: frame totals are queued with their
// expected strobe cycle when the final sample is driven and checked on valid_out.
module tb_adder_tree_accumulator;

    localparam int DATA_WIDTH  = 20;
    localparam int COUNT_WIDTH = 16;
    localparam int ACC_WIDTH   = DATA_WIDTH + COUNT_WIDTH;

    typedef struct {
        longint total;
        int     cyc;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         enable;
    logic                         sync;
    logic [COUNT_WIDTH-1:0]       frame_len;
    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         valid_out;
    logic signed [ACC_WIDTH-1:0]  data_out;
    logic                         frame_err;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    adder_tree_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .sync     (sync),
        .frame_len(frame_len),
        .valid_in (valid_in),
        .data_in  (data_in),
        .valid_out(valid_out),
        .data_out (data_out),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (q.size() == 0) begin
                chk("unexpected_valid_out", longint'(valid_out), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("frame_total", longint'(data_out), e.total);
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    // One clock of stimulus; 'last' queues the frame total expected next cycle.
    task automatic feed(input logic v, input longint d, input logic s,
                        input logic last, input longint exp);
        exp_t e;
        @(posedge clk);
        #1;
        valid_in = v;
        data_in  = d[DATA_WIDTH-1:0];
        sync     = s;
        if (last) begin
            e.total = exp;
            e.cyc   = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) feed(1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic restart(input int len);
        @(posedge clk);
        #1;
        enable   = 1'b0;
        valid_in = 1'b0;
        sync     = 1'b0;
        @(posedge clk);
        #1;
        enable    = 1'b1;
        frame_len = len[COUNT_WIDTH-1:0];
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        sync      = 1'b0;
        frame_len = '0;
        valid_in  = 1'b0;
        data_in   = '0;
        #23;
        chk("rst_valid_out", longint'(valid_out), 0);
        chk("rst_data_out", longint'(data_out), 0);
        chk("rst_frame_err", longint'(frame_err), 0);
        rst_n = 1'b1;

        // Two back-to-back frames of 4.
        restart(4);
        for (int i = 1; i <= 8; i++)
            feed(1'b1, i, 1'b0, (i % 4) == 0, (i == 4) ? 10 : 26);
        idle(2);

        // Most negative input, then a maximal frame of the most positive input.
        restart(3);
        for (int i = 1; i <= 3; i++)
            feed(1'b1, -524288, 1'b0, i == 3, -1572864);
        restart(65535);
        for (int i = 1; i <= 65535; i++)
            feed(1'b1, 524287, 1'b0, i == 65535, 64'sd34359148545);
        idle(2);

        // Gapped strobes hold the accumulator.
        restart(4);
        for (int i = 1; i <= 4; i++) begin
            feed(1'b1, 5, 1'b0, i == 4, 20);
            idle(2);
        end

        // Mid-frame sync: truncated frame produces nothing, 7 opens the new one.
        restart(4);
        feed(1'b1, 1, 1'b0, 1'b0, 0);
        feed(1'b1, 1, 1'b0, 1'b0, 0);
        feed(1'b1, 7, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 3; i++)
            feed(1'b1, 1, 1'b0, i == 3, 10);
        idle(2);

        // Zero frame length raises the sticky error; enable low clears it.
        restart(0);
        feed(1'b1, 5, 1'b0, 1'b0, 0);
        feed(1'b1, 5, 1'b0, 1'b0, 0);
        idle(1);
        @(negedge clk);
        chk("frame_err_set", longint'(frame_err), 1);
        enable = 1'b0;
        idle(2);
        @(negedge clk);
        chk("frame_err_clear", longint'(frame_err), 0);

        // Frame length 1: every sample is a total, including a sync'd one.
        restart(1);
        feed(1'b1, 3, 1'b0, 1'b1, 3);
        feed(1'b1, -4, 1'b0, 1'b1, -4);
        feed(1'b1, 100, 1'b0, 1'b1, 100);
        feed(1'b1, 9, 1'b1, 1'b1, 9);
        idle(2);

        // Asynchronous reset in the middle of a frame.
        restart(4);
        feed(1'b1, 2, 1'b0, 1'b0, 0);
        feed(1'b1, 2, 1'b0, 1'b0, 0);
        rst_n    = 1'b0;
        enable   = 1'b0;
        valid_in = 1'b0;
        #2;
        chk("midrst_data_out", longint'(data_out), 0);
        chk("midrst_valid_out", longint'(valid_out), 0);
        chk("midrst_frame_err", longint'(frame_err), 0);
        #5;
        rst_n = 1'b1;
        restart(4);
        for (int i = 1; i <= 4; i++)
            feed(1'b1, 2, 1'b0, i == 4, 8);

        // Enable dropped mid-frame: no strobe, data_out keeps last total.
        feed(1'b1, 3, 1'b0, 1'b0, 0);
        feed(1'b1, 3, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        enable   = 1'b0;
        valid_in = 1'b1;
        data_in  = 50;
        idle(2);
        @(negedge clk);
        chk("held_data_out", longint'(data_out), 8);
        restart(2);
        feed(1'b1, 6, 1'b0, 1'b0, 0);
        feed(1'b1, 7, 1'b0, 1'b1, 13);
        idle(3);

        chk("pending_frames", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
